// File: rtl/gray_conv_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gray_conv_arbiter_pkg
// Description : Shared definitions for the round-robin Gray-conversion
//               arbiter: converter width, default requester count, FSM state
//               encoding and the id-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package gray_conv_arbiter_pkg;

  // Width of the shared binary-to-Gray converter.
  localparam int GRAY_W = 4;

  // Default number of requesters sharing the converter.
  localparam int NREQ_DEFAULT = 4;

  // Arbiter FSM: IDLE looks for a winner, OUT holds a result until accepted.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OUT  = 1'b1
  } state_e;

  // Ceiling log2 with a floor of 1 so a 2-requester arbiter still gets a
  // 1-bit id.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage : gray_conv_arbiter_pkg
`default_nettype wire

// File: rtl/gray_conv_arbiter_b_g.sv
`default_nettype none
// ============================================================================
// Module      : b_g
// Description : Combinational 4-bit binary-to-Gray converter shared by all
//               requesters. The MSB passes through; each lower Gray bit is
//               the XOR of the binary bit and its upper neighbour.
// Ports       : b - binary code in
//               g - Gray code out
// Revision    : 1.0 - initial release
// ============================================================================
module b_g
  import gray_conv_arbiter_pkg::*;
(
  input  logic [GRAY_W-1:0] b,
  output logic [GRAY_W-1:0] g
);

  assign g = b ^ (b >> 1);

endmodule : b_g
`default_nettype wire

// File: rtl/gray_conv_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gray_conv_arbiter
// Description : Round-robin scheduler sharing one binary-to-Gray converter
//               between NREQ requesters. A winner is chosen in IDLE, its code
//               captured, and the converted result held on a valid/ready
//               channel (tagged with the requester id) until accepted.
// Ports       : clk       - rising-edge clock
//               rst_n     - asynchronous active-low reset
//               req       - per-requester request level
//               bin_in    - flattened codes, requester i at [i*WIDTH +: WIDTH]
//               gnt       - one-hot grant pulse, code accepted this cycle
//               out_valid - result valid
//               out_ready - downstream accepts result
//               out_gray  - Gray code of the granted binary input
//               out_id    - index of the requester that produced out_gray
//               busy      - high while a result is held
// Revision    : 1.0 - initial release
// ============================================================================
module gray_conv_arbiter
  import gray_conv_arbiter_pkg::*;
#(
  parameter int NREQ  = NREQ_DEFAULT,
  parameter int WIDTH = GRAY_W,
  parameter int IDW   = clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] bin_in,
  output logic [NREQ-1:0]       gnt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_gray,
  output logic [IDW-1:0]        out_id,
  output logic                  busy
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e           state_q;
  state_e           state_d;
  logic [IDW-1:0]   rr_last_q;
  logic [IDW-1:0]   rr_last_d;
  logic [IDW-1:0]   out_id_q;
  logic [IDW-1:0]   out_id_d;
  logic [WIDTH-1:0] cap_bin_q;
  logic [WIDTH-1:0] cap_bin_d;

  // --------------------------------------------------------------------------
  // Round-robin winner search
  // --------------------------------------------------------------------------
  logic             win_found;
  logic [IDW-1:0]   win_id;
  logic [WIDTH-1:0] win_bin;
  int               best_off;
  int               off;

  assign win_found = |req;

  // Each requester's distance from the slot just after rr_last; the smallest
  // distance among active requesters wins. Distances are unique, so at most
  // one requester can win.
  always_comb begin : rr_search
    best_off = NREQ;
    off      = 0;
    win_id   = '0;
    for (int i = 0; i < NREQ; i++) begin
      off = (i + NREQ - 1 - int'(rr_last_q)) % NREQ;
      if (req[i] && (off < best_off)) begin
        best_off = off;
        win_id   = IDW'(i);
      end
    end
  end

  // Only the winner's slice reaches the capture register; other slices are
  // never looked at, so unknowns on idle requesters cannot leak through.
  always_comb begin : win_mux
    win_bin = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_id == IDW'(i)) begin
        win_bin = bin_in[i*WIDTH +: WIDTH];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin : next_state
    state_d   = state_q;
    rr_last_d = rr_last_q;
    out_id_d  = out_id_q;
    cap_bin_d = cap_bin_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          cap_bin_d = win_bin;
          out_id_d  = win_id;
          rr_last_d = win_id;
          state_d   = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset leaves rr_last on the last slot so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin : regs
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_last_q <= IDW'(NREQ - 1);
      out_id_q  <= '0;
      cap_bin_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      out_id_q  <= out_id_d;
      cap_bin_q <= cap_bin_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // The grant is combinational, so it is also gated by rst_n: while reset is
  // held the FSM sits in IDLE, and an ungated grant would pulse to requesters
  // whose codes will never be captured.
  for (genvar i = 0; i < NREQ; i++) begin : g_gnt
    assign gnt[i] = rst_n && (state_q == IDLE) && win_found &&
                    (win_id == IDW'(i));
  end

  assign out_valid = (state_q == OUT);
  assign busy      = (state_q == OUT);
  assign out_id    = out_id_q;

  b_g u_b_g (
    .b (cap_bin_q),
    .g (out_gray)
  );

endmodule : gray_conv_arbiter
`default_nettype wire

// File: tb/tb_gray_conv_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_gray_conv_arbiter
// Description : Self-checking bench for gray_conv_arbiter. A reference model
//               predicts grants and pushes expected results into a queue; an
//               independent monitor pops and compares whenever the DUT
//               presents a result. Directed phases are followed by a
//               randomized phase that respects the requester contract.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_conv_arbiter;
  import gray_conv_arbiter_pkg::*;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] bin_in = '0;
  logic                  out_ready = 1'b0;
  logic [NREQ-1:0]       gnt;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_gray;
  logic [IDW-1:0]        out_id;
  logic                  busy;

  gray_conv_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH),
    .IDW   (IDW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .bin_in    (bin_in),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_gray  (out_gray),
    .out_id    (out_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] gray;
  } res_t;

  res_t exp_q[$];
  res_t got_log[$];
  int   gnt_log[$];

  // Gray table built by reflection (prefix 0 to the list, then 1 to its mirror).
  logic [WIDTH-1:0] gray_tab [16];

  task automatic build_gray_tab();
    int lst[$];
    int n;
    lst = '{0, 1};
    for (int b = 2; b <= WIDTH; b++) begin
      n = lst.size();
      for (int j = n - 1; j >= 0; j--) lst.push_back(lst[j] | (1 << (b - 1)));
    end
    for (int k = 0; k < 16; k++) gray_tab[k] = WIDTH'(lst[k]);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
    int idx;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (last + k) % NREQ;
      if (((r >> idx) & 1) != 0) return idx;
    end
    return -1;
  endfunction

  // --------------------------------------------------------------------------
  // Reference model / scoreboard producer
  // --------------------------------------------------------------------------
  bit                    m_busy = 1'b0;
  int                    m_last = NREQ - 1;
  int                    sb_w;
  logic [NREQ-1:0]       sb_eg;
  logic [NREQ*WIDTH-1:0] sb_sh;
  res_t                  sb_r;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_last = NREQ - 1;
      exp_q.delete();
    end else if (!m_busy) begin
      sb_w  = rr_pick(req, m_last);
      sb_eg = (sb_w < 0) ? '0 : NREQ'(1 << sb_w);
      check("gnt_idle", 32'(gnt), 32'(sb_eg));
      check("busy_valid_idle", {30'd0, busy, out_valid}, 32'd0);
      if (sb_w >= 0) begin
        sb_sh     = bin_in >> (sb_w * WIDTH);
        sb_r.id   = IDW'(sb_w);
        sb_r.gray = gray_tab[sb_sh[WIDTH-1:0]];
        exp_q.push_back(sb_r);
        gnt_log.push_back(sb_w);
        m_last = sb_w;
        m_busy = 1'b1;
      end
    end else begin
      check("gnt_out", 32'(gnt), 32'd0);
      check("busy_valid_out", {30'd0, busy, out_valid}, 32'd3);
      if (out_ready) m_busy = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Output monitor / scoreboard consumer
  // --------------------------------------------------------------------------
  res_t mon_r;

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        check("out_gray", 32'(out_gray), 32'(exp_q[0].gray));
        check("out_id", 32'(out_id), 32'(exp_q[0].id));
        if (out_ready) begin
          mon_r.id   = out_id;
          mon_r.gray = out_gray;
          got_log.push_back(mon_r);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_bin(input int i, input logic [WIDTH-1:0] code);
    logic [NREQ*WIDTH-1:0] m;
    logic [NREQ*WIDTH-1:0] c;
    m = {{(NREQ*WIDTH-WIDTH){1'b0}}, {WIDTH{1'b1}}} << (i * WIDTH);
    c = {{(NREQ*WIDTH-WIDTH){1'b0}}, code} << (i * WIDTH);
    bin_in = (bin_in & ~m) | c;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  logic [NREQ-1:0] g_seen;
  logic [NREQ-1:0] nreq;
  int              has1;
  int              exp_rr_id [5];
  logic [3:0]      exp_rr_gr [5];

  initial begin
    build_gray_tab();
    exp_rr_id = '{0, 1, 2, 3, 0};
    exp_rr_gr = '{4'b1101, 4'b1000, 4'b1111, 4'b0010, 4'b1101};

    // Reset values
    step(3);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_gray", 32'(out_gray), 32'd0);
    check("rst_id", 32'(out_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    // Reset while a result is held
    req = 4'b0001; set_bin(0, 4'b0101); out_ready = 1'b0;
    step(3);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_gnt", 32'(gnt), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    step(2);
    out_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    check("post_rst_gnt", 32'(gnt), 32'b0001);
    step(1);
    req = '0;
    check("post_rst_valid", 32'(out_valid), 32'd1);
    check("post_rst_gray", 32'(out_gray), 32'b0111);
    check("post_rst_id", 32'(out_id), 32'd0);
    step(1);
    check("post_rst_idle", 32'(out_valid), 32'd0);

    // Round-robin over four steady requesters
    do_reset();
    gnt_log.delete(); got_log.delete();
    bin_in = {4'd3, 4'd10, 4'd15, 4'd9};
    out_ready = 1'b1;
    req = 4'b1111;
    step(10);
    req = '0;
    check("rr_count", 32'(got_log.size()), 32'd5);
    for (int k = 0; k < 5 && k < got_log.size(); k++) begin
      check("rr_order", 32'(gnt_log[k]), 32'(exp_rr_id[k]));
      check("rr_id", 32'(got_log[k].id), 32'(exp_rr_id[k]));
      check("rr_gray", 32'(got_log[k].gray), 32'(exp_rr_gr[k]));
    end

    // Backpressure
    step(1);
    out_ready = 1'b0;
    req = 4'b0100; set_bin(2, 4'b1100);
    step(1);
    req = '0;
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_gray", 32'(out_gray), 32'b1010);
      check("bp_id", 32'(out_id), 32'd2);
      check("bp_gnt", 32'(gnt), 32'd0);
      step(1);
    end
    out_ready = 1'b1;
    step(1);
    check("bp_release_idle", 32'(out_valid), 32'd0);

    // Fairness under contention, then a third requester joins
    gnt_log.delete();
    req = 4'b1001;
    step(8);
    req = 4'b1011;
    step(8);
    req = '0;
    check("fair_count", 32'(gnt_log.size()), 32'd8);
    if (gnt_log.size() >= 6) begin
      for (int k = 0; k < 4; k++) begin
        check("fair_member", 32'(gnt_log[k] == 0 || gnt_log[k] == 3), 32'd1);
        if (k > 0) check("fair_alternate", 32'(gnt_log[k] != gnt_log[k-1]), 32'd1);
      end
      check("fair_req1_served", 32'(gnt_log[4] == 1 || gnt_log[5] == 1), 32'd1);
    end

    // Withdrawal while the arbiter is busy
    step(1);
    gnt_log.delete(); got_log.delete();
    out_ready = 1'b0;
    req = 4'b0001; set_bin(0, 4'd6); set_bin(1, 4'd11);
    step(1);
    req = 4'b0010;
    step(1);
    req = '0;
    step(2);
    out_ready = 1'b1;
    step(3);
    check("wd_grants", 32'(gnt_log.size()), 32'd1);
    has1 = 0;
    foreach (got_log[k]) if (got_log[k].id == 1) has1 = 1;
    check("wd_no_id1", 32'(has1), 32'd0);

    // Exhaustive conversion through a single requester
    got_log.delete();
    for (int b = 0; b < 16; b++) begin
      req = 4'b0010; set_bin(1, 4'(b));
      step(1);
      req = '0;
      step(1);
    end
    check("ex_count", 32'(got_log.size()), 32'd16);
    if (got_log.size() == 16) begin
      check("ex_8", 32'(got_log[8].gray), 32'b1100);
      check("ex_7", 32'(got_log[7].gray), 32'b0100);
      check("ex_15", 32'(got_log[15].gray), 32'b1000);
      for (int b = 0; b < 16; b++) check("ex_id", 32'(got_log[b].id), 32'd1);
    end

    // Randomized traffic following the requester contract
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      g_seen = gnt;
      @(posedge clk);
      #1;
      if (cyc == 1000) rst_n = 1'b0;
      if (cyc == 1003) rst_n = 1'b1;
      nreq = req;
      for (int i = 0; i < NREQ; i++) begin
        if (((g_seen >> i) & 1) != 0) begin
          if ($urandom_range(1) == 1) nreq = nreq | NREQ'(1 << i);
          else nreq = nreq & ~NREQ'(1 << i);
          set_bin(i, 4'($urandom_range(15)));
        end else if (((req >> i) & 1) != 0) begin
          if ($urandom_range(19) == 0) nreq = nreq & ~NREQ'(1 << i);
        end else if ($urandom_range(9) < 3) begin
          nreq = nreq | NREQ'(1 << i);
          set_bin(i, 4'($urandom_range(15)));
        end
      end
      req = nreq;
      out_ready = ($urandom_range(9) < 7);
    end

    // Drain
    req = '0;
    out_ready = 1'b1;
    step(4);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("drain_idle", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_gray_conv_arbiter
`default_nettype wire
